// File: rtl/window_pkg.sv
// Shared definitions for the window motor driver and the controller bench:
// state encoding, default travel limit and a small state classifier.
package window_pkg;

    // Default number of cycles the motor may run in a single move.
    localparam int TRAVEL_MAX_DEFAULT = 8;

    typedef enum logic [2:0] {
        HOME    = 3'd0,
        CLOSED  = 3'd1,
        OPENING = 3'd2,
        OPEN    = 3'd3,
        CLOSING = 3'd4,
        FAULT   = 3'd5
    } win_state_e;

    // True for every state in which the motor is being driven.
    function automatic logic is_driving(input win_state_e s);
        return (s == HOME) || (s == OPENING) || (s == CLOSING);
    endfunction

endpackage

// File: rtl/window_motor_driver_if.sv
// Command / limit / status bundle between the window controller, the
// limit-switch pins and the motor driver.
interface window_motor_driver_if;

    logic OpenCW;
    logic OpenCCW;
    logic LimitOpen;
    logic LimitClosed;
    logic MotorCW;
    logic MotorCCW;
    logic Busy;
    logic WinOpen;
    logic WinClosed;
    logic Fault;

    // Controller / pin side: issues commands, supplies limits, sees status.
    modport master (
        output OpenCW, OpenCCW, LimitOpen, LimitClosed,
        input  MotorCW, MotorCCW, Busy, WinOpen, WinClosed, Fault
    );

    // Driver side.
    modport slave (
        input  OpenCW, OpenCCW, LimitOpen, LimitClosed,
        output MotorCW, MotorCCW, Busy, WinOpen, WinClosed, Fault
    );

endinterface

// File: rtl/window_motor_driver_travel_timer.sv
// Travel watchdog: counts cycles spent driving the motor in one move and
// flags the last permitted cycle so the FSM can declare a timeout.
module travel_timer
    import window_pkg::*;
#(
    parameter int TRAVEL_MAX = TRAVEL_MAX_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic Clear,
    input  logic Enable,
    output logic Expired
);

    localparam int CNT_W = $clog2(TRAVEL_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TRAVEL_MAX - 1);
    localparam logic [CNT_W-1:0] TOP_CNT  = CNT_W'(TRAVEL_MAX);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: Clear wins, otherwise count while enabled, saturating so
    // the counter can never wrap back into the legal range.
    always_comb begin
        count_d = count_q;
        if (Clear) begin
            count_d = '0;
        end else if (Enable && (count_q != TOP_CNT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Expired = Enable && (count_q == LAST_CNT);

endmodule

// File: rtl/window_motor_driver.sv
// Window motor driver: turns one-cycle open/close commands into sustained
// motor drive, stops on the limit switches and latches a fault on travel
// timeout or contradictory limits. All outputs are registered Moore outputs.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   HOME    | after reset, closing until LimitClosed seen
//   CLOSED  | window at closed end, motor off
//   OPENING | driving towards open end
//   OPEN    | window at open end, motor off
//   CLOSING | driving towards closed end
//   FAULT   | timeout or both limits high; only reset exits
module window_motor_driver
    import window_pkg::*;
#(
    parameter int TRAVEL_MAX = TRAVEL_MAX_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    window_motor_driver_if.slave   bus
);

    win_state_e state_q;
    win_state_e state_d;

    logic motor_cw_q;
    logic motor_ccw_q;
    logic busy_q;
    logic win_open_q;
    logic win_closed_q;
    logic fault_q;

    logic cmd_cw;
    logic cmd_ccw;
    logic both_limits;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    // A command counts only when exactly one of the two lines is high.
    assign cmd_cw      = bus.OpenCW  && !bus.OpenCCW;
    assign cmd_ccw     = bus.OpenCCW && !bus.OpenCW;
    assign both_limits = bus.LimitOpen && bus.LimitClosed;

    // The timer restarts on every entry to a driving state, including a
    // direct reversal between OPENING and CLOSING.
    assign timer_enable = is_driving(state_q);
    assign timer_clear  = is_driving(state_d) && (state_d != state_q);

    travel_timer #(
        .TRAVEL_MAX (TRAVEL_MAX)
    ) u_travel_timer (
        .clock   (clock),
        .reset   (reset),
        .Clear   (timer_clear),
        .Enable  (timer_enable),
        .Expired (timer_expired)
    );

    // Next-state logic; in moving states the order is contradictory limits,
    // terminating limit, reversing command, then timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOME: begin
                if (both_limits) begin
                    state_d = FAULT;
                end else if (bus.LimitClosed) begin
                    state_d = CLOSED;
                end else if (timer_expired) begin
                    state_d = FAULT;
                end
            end
            CLOSED: begin
                if (both_limits) begin
                    state_d = FAULT;
                end else if (cmd_cw) begin
                    state_d = OPENING;
                end
            end
            OPENING: begin
                if (both_limits) begin
                    state_d = FAULT;
                end else if (bus.LimitOpen) begin
                    state_d = OPEN;
                end else if (cmd_ccw) begin
                    state_d = CLOSING;
                end else if (timer_expired) begin
                    state_d = FAULT;
                end
            end
            OPEN: begin
                if (both_limits) begin
                    state_d = FAULT;
                end else if (cmd_ccw) begin
                    state_d = CLOSING;
                end
            end
            CLOSING: begin
                if (both_limits) begin
                    state_d = FAULT;
                end else if (bus.LimitClosed) begin
                    state_d = CLOSED;
                end else if (cmd_cw) begin
                    state_d = OPENING;
                end else if (timer_expired) begin
                    state_d = FAULT;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

    // State register with outputs decoded from the next state, so each
    // output flop reflects exactly the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HOME;
            motor_cw_q   <= 1'b0;
            motor_ccw_q  <= 1'b1;
            busy_q       <= 1'b1;
            win_open_q   <= 1'b0;
            win_closed_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            motor_cw_q   <= (state_d == OPENING);
            motor_ccw_q  <= (state_d == HOME) || (state_d == CLOSING);
            busy_q       <= is_driving(state_d);
            win_open_q   <= (state_d == OPEN);
            win_closed_q <= (state_d == CLOSED);
            fault_q      <= (state_d == FAULT);
        end
    end

    assign bus.MotorCW   = motor_cw_q;
    assign bus.MotorCCW  = motor_ccw_q;
    assign bus.Busy      = busy_q;
    assign bus.WinOpen   = win_open_q;
    assign bus.WinClosed = win_closed_q;
    assign bus.Fault     = fault_q;

endmodule

// File: tb/tb_window_motor_driver.sv
// Bench for window_motor_driver: directed scenarios followed by random
// commands, limits and resets, all compared cycle by cycle against a
// behavioural model of the window.
module tb_window_motor_driver;

    localparam int TM = 8;

    logic clock;
    logic reset;

    window_motor_driver_if wif();

    window_motor_driver #(
        .TRAVEL_MAX (TM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (wif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: current mode letter and cycles the motor has run in this move.
    //   "H" homing, "C" closed, "o" opening, "O" open, "c" closing, "F" fault
    byte md  = "H";
    int  drv = 0;

    int cw_cnt  = 0;
    int ccw_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input bit cw, input bit ccw, input bit lo,
                              input bit lc, input bit rst);
        byte nxt;
        bit  both;
        bit  vcw;
        bit  vccw;
        if (rst) begin
            md  = "H";
            drv = 1;
            return;
        end
        both = lo && lc;
        vcw  = cw && !ccw;
        vccw = ccw && !cw;
        nxt  = md;
        case (md)
            "H": if (both) nxt = "F"; else if (lc) nxt = "C";
                 else if (drv >= TM) nxt = "F";
            "C": if (both) nxt = "F"; else if (vcw) nxt = "o";
            "O": if (both) nxt = "F"; else if (vccw) nxt = "c";
            "o": if (both) nxt = "F"; else if (lo) nxt = "O";
                 else if (vccw) nxt = "c"; else if (drv >= TM) nxt = "F";
            "c": if (both) nxt = "F"; else if (lc) nxt = "C";
                 else if (vcw) nxt = "o"; else if (drv >= TM) nxt = "F";
            default: nxt = "F";
        endcase
        if (nxt == "o" || nxt == "c" || nxt == "H")
            drv = (nxt != md) ? 1 : drv + 1;
        md = nxt;
    endtask

    task automatic step(input bit cw, input bit ccw, input bit lo,
                        input bit lc, input bit rst);
        wif.OpenCW      = cw;
        wif.OpenCCW     = ccw;
        wif.LimitOpen   = lo;
        wif.LimitClosed = lc;
        reset           = rst;
        @(posedge clock);
        model_edge(cw, ccw, lo, lc, rst);
        @(negedge clock);
        cyc++;
        check_eq("MotorCW",   32'(wif.MotorCW),   32'(md == "o"));
        check_eq("MotorCCW",  32'(wif.MotorCCW),  32'(md == "H" || md == "c"));
        check_eq("Busy",      32'(wif.Busy),      32'(md == "H" || md == "o" || md == "c"));
        check_eq("WinOpen",   32'(wif.WinOpen),   32'(md == "O"));
        check_eq("WinClosed", 32'(wif.WinClosed), 32'(md == "C"));
        check_eq("Fault",     32'(wif.Fault),     32'(md == "F"));
        if (wif.MotorCW === 1'b1)  cw_cnt++;
        if (wif.MotorCCW === 1'b1) ccw_cnt++;
    endtask

    task automatic idle(input int n, input bit lo, input bit lc);
        for (int i = 0; i < n; i++) step(0, 0, lo, lc, 0);
    endtask

    // Reset, then let HOME finish on LimitClosed.
    task automatic go_closed();
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
    endtask

    initial begin
        wif.OpenCW      = 1'b0;
        wif.OpenCCW     = 1'b0;
        wif.LimitOpen   = 1'b0;
        wif.LimitClosed = 1'b0;
        reset           = 1'b1;

        // Reset / home: HOME visible for 4 cycles, closed on the 5th.
        cw_cnt = 0; ccw_cnt = 0;
        step(0, 0, 0, 0, 1);
        check_eq("rst_motorccw", 32'(wif.MotorCCW), 32'd1);
        check_eq("rst_busy",     32'(wif.Busy),     32'd1);
        idle(3, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(2, 0, 1);
        check_eq("home_ccw_cycles", 32'(ccw_cnt), 32'd4);
        check_eq("home_closed",     32'(wif.WinClosed), 32'd1);

        // Open then close.
        cw_cnt = 0; ccw_cnt = 0;
        step(1, 0, 0, 1, 0);
        idle(3, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(2, 1, 0);
        check_eq("open_cw_cycles", 32'(cw_cnt), 32'd4);
        check_eq("open_state",     32'(wif.WinOpen), 32'd1);
        step(0, 1, 1, 0, 0);
        idle(4, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(2, 0, 1);
        check_eq("close_ccw_cycles", 32'(ccw_cnt), 32'd5);
        check_eq("close_state",      32'(wif.WinClosed), 32'd1);

        // Reversal after 3 cycles of OPENING, then timeout while closing.
        cw_cnt = 0; ccw_cnt = 0;
        step(1, 0, 0, 1, 0);
        idle(2, 0, 0);
        step(0, 1, 0, 0, 0);
        check_eq("rev_cw_off", 32'(wif.MotorCW),  32'd0);
        check_eq("rev_ccw_on", 32'(wif.MotorCCW), 32'd1);
        idle(10, 0, 0);
        check_eq("rev_cw_cycles",  32'(cw_cnt),  32'd3);
        check_eq("rev_ccw_cycles", 32'(ccw_cnt), 32'd8);
        check_eq("rev_fault",      32'(wif.Fault), 32'd1);

        // Timeout from CLOSED, then commands ignored, then reset recovers.
        go_closed();
        cw_cnt = 0; ccw_cnt = 0;
        step(1, 0, 0, 1, 0);
        idle(12, 0, 0);
        check_eq("to_cw_cycles", 32'(cw_cnt), 32'd8);
        check_eq("to_fault",     32'(wif.Fault), 32'd1);
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(2, 0, 1);
        check_eq("to_sticky", 32'(wif.Fault), 32'd1);
        step(0, 0, 0, 0, 1);
        check_eq("to_reset_home", 32'(wif.MotorCCW), 32'd1);

        // Illegal inputs.
        step(0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        check_eq("both_cmd_closed", 32'(wif.WinClosed), 32'd1);
        step(1, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check_eq("cw_in_open", 32'(wif.WinOpen), 32'd1);
        step(0, 0, 1, 1, 0);
        check_eq("both_lim_open", 32'(wif.Fault), 32'd1);

        // Random phase.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            bit r_cw;
            bit r_ccw;
            bit r_lo;
            bit r_lc;
            bit r_rst;
            r_cw  = ($urandom % 6) == 0;
            r_ccw = ($urandom % 6) == 0;
            r_lo  = ($urandom % 5) == 0;
            r_lc  = ($urandom % 5) == 0;
            r_rst = ($urandom % 60) == 0;
            step(r_cw, r_ccw, r_lo, r_lc, r_rst);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
